// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the byte-serial RAM arbiter.
// Width codes, FSM/owner encodings and the byte-count helper live here.
package mem_arbiter_pkg;

    localparam logic [1:0]  MemByte   = 2'b00;
    localparam logic [1:0]  MemHalf   = 2'b01;
    localparam logic [1:0]  MemWord   = 2'b10;
    localparam logic [31:0] ZeroWord  = 32'h0000_0000;
    localparam logic        RstEnable = 1'b1;

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} ArbState;
    typedef enum logic {OwnIF, OwnMEM} Owner;

    // Width code 2'b11 is served as a full word.
    function automatic logic [2:0] byteCount(input logic [1:0] width);
        case (width)
            MemByte: byteCount = 3'd1;
            MemHalf: byteCount = 3'd2;
            default: byteCount = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side bus of the arbiter: the IF fetch port and the MEM load/store port.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32
);

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [31:0]       if_rdata;
    logic              if_done;

    logic              mem_req;
    logic              mem_we;
    logic [1:0]        mem_width;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_done;

    modport master (
        output if_req, if_addr, mem_req, mem_we, mem_width, mem_addr, mem_wdata,
        input  if_rdata, if_done, mem_rdata, mem_done
    );

    modport slave (
        input  if_req, if_addr, mem_req, mem_we, mem_width, mem_addr, mem_wdata,
        output if_rdata, if_done, mem_rdata, mem_done
    );

endinterface

// File: rtl/mem_byte_seq.sv
// Byte sequencer: walks a latched (addr, count, we, wdata) job one RAM byte per cycle,
// scattering store bytes and assembling load bytes little-endian.
module mem_byte_seq
    import mem_arbiter_pkg::*;
#(
    parameter int RAM_AW = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              run_i,
    input  logic [RAM_AW-1:0] addr_i,
    input  logic [2:0]        count_i,
    input  logic              we_i,
    input  logic [31:0]       wdata_i,
    input  logic [7:0]        ramDout_i,
    output logic              last_o,
    output logic [31:0]       rdata_o,
    output logic [RAM_AW-1:0] ramAddr_o,
    output logic              ramWr_o,
    output logic [7:0]        ramDin_o
);

    logic [2:0]        count_q;
    logic              we_q;
    logic [31:0]       wdata_q;
    logic [2:0]        byteCnt_q, byteCnt_d;
    logic [31:0]       rbuf_q, rbuf_d;
    logic [RAM_AW-1:0] ramAddr_q, ramAddr_d;
    logic              ramWr_q, ramWr_d;
    logic [7:0]        ramDin_q, ramDin_d;
    logic [1:0]        lane;
    logic [2:0]        nextIdx;

    // Reads lag addresses by one cycle, so byte i lands while the counter reads i+1.
    always_comb begin
        lane      = 2'(byteCnt_q - 3'd1);
        nextIdx   = byteCnt_q + 3'd1;
        last_o    = run_i && (we_q ? (byteCnt_q == count_q - 3'd1) : (byteCnt_q == count_q));
        byteCnt_d = byteCnt_q;
        rbuf_d    = rbuf_q;
        ramAddr_d = ramAddr_q;
        ramDin_d  = ramDin_q;
        ramWr_d   = 1'b0;
        if (start_i) begin
            byteCnt_d = 3'd0;
            rbuf_d    = ZeroWord;
            ramAddr_d = addr_i;
            ramDin_d  = wdata_i[7:0];
            ramWr_d   = we_i;
        end else if (run_i) begin
            byteCnt_d = nextIdx;
            if (!we_q && byteCnt_q != 3'd0) begin
                rbuf_d = rbuf_q | ({24'h0, ramDout_i} << {lane, 3'b000});
            end
            if (nextIdx < count_q) begin
                ramAddr_d = ramAddr_q + RAM_AW'(1);
                ramDin_d  = wdata_q[{nextIdx[1:0], 3'b000} +: 8];
                ramWr_d   = we_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            count_q   <= 3'd0;
            we_q      <= 1'b0;
            wdata_q   <= ZeroWord;
            byteCnt_q <= 3'd0;
            rbuf_q    <= ZeroWord;
            ramAddr_q <= '0;
            ramWr_q   <= 1'b0;
            ramDin_q  <= 8'h00;
        end else begin
            if (start_i) begin
                count_q <= count_i;
                we_q    <= we_i;
                wdata_q <= wdata_i;
            end
            byteCnt_q <= byteCnt_d;
            rbuf_q    <= rbuf_d;
            ramAddr_q <= ramAddr_d;
            ramWr_q   <= ramWr_d;
            ramDin_q  <= ramDin_d;
        end
    end

    assign rdata_o   = rbuf_d;
    assign ramAddr_o = ramAddr_q;
    assign ramWr_o   = ramWr_q;
    assign ramDin_o  = ramDin_q;

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter FSM sharing the byte-wide RAM between instruction fetch and the MEM stage.
// MEM wins ties because it belongs to the older instruction.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int RAM_AW = 17
) (
    input  logic              clk,
    input  logic              rst,
    mem_arbiter_if.slave      bus,
    output logic [RAM_AW-1:0] ram_a_o,
    output logic              ram_wr_o,
    output logic [7:0]        ram_din_o,
    input  logic [7:0]        ram_dout_i
);

    ArbState           state_q, state_d;
    Owner              owner_q, owner_d;
    logic [31:0]       ifRdata_q, ifRdata_d;
    logic [31:0]       memRdata_q, memRdata_d;
    logic              start;
    logic [ADDR_W-1:0] jobAddr;
    logic [2:0]        jobCount;
    logic              jobWe;
    logic              seqLast;
    logic [31:0]       seqRdata;
    logic              unusedAddrBits;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        ifRdata_d  = ifRdata_q;
        memRdata_d = memRdata_q;
        start      = 1'b0;
        jobAddr    = bus.if_addr;
        jobCount   = 3'd4;
        jobWe      = 1'b0;
        if (bus.mem_req) begin
            jobAddr  = bus.mem_addr;
            jobCount = byteCount(bus.mem_width);
            jobWe    = bus.mem_we;
        end
        case (state_q)
            IDLE: begin
                if (bus.mem_req) begin
                    start   = 1'b1;
                    owner_d = OwnMEM;
                    state_d = bus.mem_we ? WR : RD;
                end else if (bus.if_req) begin
                    start   = 1'b1;
                    owner_d = OwnIF;
                    state_d = RD;
                end
            end
            RD: begin
                if (seqLast) begin
                    state_d = DONE;
                    if (owner_q == OwnIF) ifRdata_d = seqRdata;
                    else                  memRdata_d = seqRdata;
                end
            end
            WR: begin
                if (seqLast) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q    <= IDLE;
            owner_q    <= OwnIF;
            ifRdata_q  <= ZeroWord;
            memRdata_q <= ZeroWord;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            ifRdata_q  <= ifRdata_d;
            memRdata_q <= memRdata_d;
        end
    end

    mem_byte_seq #(
        .RAM_AW(RAM_AW)
    ) u_seq (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start),
        .run_i     ((state_q == RD) || (state_q == WR)),
        .addr_i    (jobAddr[RAM_AW-1:0]),
        .count_i   (jobCount),
        .we_i      (jobWe),
        .wdata_i   (bus.mem_wdata),
        .ramDout_i (ram_dout_i),
        .last_o    (seqLast),
        .rdata_o   (seqRdata),
        .ramAddr_o (ram_a_o),
        .ramWr_o   (ram_wr_o),
        .ramDin_o  (ram_din_o)
    );

    // Address bits above the RAM window are deliberately ignored.
    assign unusedAddrBits = ^jobAddr[ADDR_W-1:RAM_AW];

    assign bus.if_done   = (state_q == DONE) && (owner_q == OwnIF);
    assign bus.mem_done  = (state_q == DONE) && (owner_q == OwnMEM);
    assign bus.if_rdata  = ifRdata_q;
    assign bus.mem_rdata = memRdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a byte RAM model plus a shadow copy that
// predicts load data and latency for each request.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int RAM_AW   = 17;
    localparam int RAM_SIZE = 1 << RAM_AW;

    typedef struct {
        logic [31:0] data;
        int          lat;
    } ExpItem;

    logic              clk = 1'b0;
    logic              rst;
    logic [RAM_AW-1:0] ramA;
    logic              ramWr;
    logic [7:0]        ramDin;
    logic [7:0]        ramDout;
    logic              loadEn;
    logic [RAM_AW-1:0] loadAddr;
    logic [7:0]        loadData;
    logic [7:0]        ram    [RAM_SIZE] = '{default: 8'h00};
    logic [7:0]        shadow [RAM_SIZE] = '{default: 8'h00};
    ExpItem            ifQ[$];
    ExpItem            memQ[$];
    int                vectors = 0;
    int                miscompares = 0;
    logic [31:0]       lastData;

    mem_arbiter_if #(.ADDR_W(32)) arbBus ();

    mem_arbiter #(.ADDR_W(32), .RAM_AW(RAM_AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (arbBus),
        .ram_a_o    (ramA),
        .ram_wr_o   (ramWr),
        .ram_din_o  (ramDin),
        .ram_dout_i (ramDout)
    );

    always #5 clk = ~clk;

    // Synchronous byte RAM: read data appears the cycle after the address.
    always @(posedge clk) begin
        if (loadEn)     ram[loadAddr] <= loadData;
        else if (ramWr) ram[ramA] <= ramDin;
        ramDout <= ram[ramA];
    end

    task automatic preloadWord(input logic [16:0] a, input logic [31:0] w);
        logic [16:0] idx;
        for (int i = 0; i < 4; i++) begin
            idx = a + 17'(i);
            @(negedge clk);
            loadEn   = 1'b1;
            loadAddr = idx;
            loadData = w[8*i +: 8];
            shadow[idx] = w[8*i +: 8];
        end
        @(negedge clk);
        loadEn = 1'b0;
    endtask

    // Issues one request, predicts its result from the shadow RAM and follows it to done.
    task automatic access(input bit isMem, input bit we, input logic [1:0] width,
                          input logic [31:0] addr, input logic [31:0] wdata, input string name);
        ExpItem      e;
        ExpItem      got;
        int          n;
        bit          seen;
        bit          isWr;
        logic [16:0] idx;
        logic        done;
        logic        otherDone;
        logic [31:0] rdata;
        isWr = isMem && we;
        n = !isMem ? 4 : (width == MemByte) ? 1 : (width == MemHalf) ? 2 : 4;
        e.data = '0;
        for (int i = 0; i < n; i++) begin
            idx = addr[16:0] + 17'(i);
            if (isWr) shadow[idx] = wdata[8*i +: 8];
            else      e.data[8*i +: 8] = shadow[idx];
        end
        e.lat = isWr ? n + 1 : n + 2;
        got = e;
        if (isMem) begin
            memQ.push_back(e);
            arbBus.mem_req   = 1'b1;
            arbBus.mem_we    = we;
            arbBus.mem_width = width;
            arbBus.mem_addr  = addr;
            arbBus.mem_wdata = wdata;
        end else begin
            ifQ.push_back(e);
            arbBus.if_req  = 1'b1;
            arbBus.if_addr = addr;
        end
        seen = 1'b0;
        for (int j = 1; j <= 20 && !seen; j++) begin
            @(negedge clk);
            done      = isMem ? arbBus.mem_done : arbBus.if_done;
            otherDone = isMem ? arbBus.if_done : arbBus.mem_done;
            rdata     = isMem ? arbBus.mem_rdata : arbBus.if_rdata;
            idx       = addr[16:0] + 17'(j - 1);
            if (j <= n) begin
                vectors++;
                if (ramA !== idx || ramWr !== isWr || (isWr && ramDin !== wdata[8*(j-1) +: 8])) begin
                    miscompares++;
                    $display("[TB] FAIL %s ram cycle %0d: got a=%h wr=%b din=%h, expected a=%h wr=%b din=%h",
                             name, j, ramA, ramWr, ramDin, idx, isWr, wdata[8*(j-1) +: 8]);
                end
            end
            vectors++;
            if (otherDone !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL %s other done: got %b, expected 0", name, otherDone);
            end
            if (done === 1'b1) begin
                if ((isMem && memQ.size() == 0) || (!isMem && ifQ.size() == 0)) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL %s done: got unexpected pulse, expected none", name);
                end else begin
                    if (isMem) got = memQ.pop_front();
                    else       got = ifQ.pop_front();
                    vectors++;
                    if (j != got.lat || ramWr !== 1'b0 || (!isWr && rdata !== got.data)) begin
                        miscompares++;
                        $display("[TB] FAIL %s done: got cycle=%0d data=%h wr=%b, expected cycle=%0d data=%h wr=0",
                                 name, j, rdata, ramWr, got.lat, got.data);
                    end
                end
                lastData = rdata;
                seen = 1'b1;
                if (isMem) arbBus.mem_req = 1'b0;
                else       arbBus.if_req = 1'b0;
            end
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL %s timeout: got no done in 20 cycles, expected done at %0d", name, e.lat);
            arbBus.mem_req = 1'b0;
            arbBus.if_req  = 1'b0;
            ifQ.delete();
            memQ.delete();
        end
        @(negedge clk);
        done  = isMem ? arbBus.mem_done : arbBus.if_done;
        rdata = isMem ? arbBus.mem_rdata : arbBus.if_rdata;
        vectors++;
        if (done !== 1'b0 || ramWr !== 1'b0 || (!isWr && rdata !== got.data)) begin
            miscompares++;
            $display("[TB] FAIL %s after done: got done=%b wr=%b data=%h, expected done=0 wr=0 data=%h",
                     name, done, ramWr, rdata, got.data);
        end
    endtask

    task automatic checkData(input string name, input logic [31:0] expected);
        vectors++;
        if (lastData !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s data: got %h, expected %h", name, lastData, expected);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        preloadWord(17'h00100, 32'h93000013);
        preloadWord(17'h00104, 32'h00000137);
        preloadWord(17'h00200, 32'hCAFEF00D);
        preloadWord(17'h00300, 32'h1234565C);
        preloadWord(17'h1FFFE, 32'h44332211);
        preloadWord(17'h00010, 32'h89ABCDEF);
        @(negedge clk);
        vectors++;
        if ({ramA, ramWr, ramDin} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset ram: got a=%h wr=%b din=%h, expected all 0", ramA, ramWr, ramDin);
        end
        vectors++;
        if ({arbBus.if_done, arbBus.mem_done, arbBus.if_rdata, arbBus.mem_rdata} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset bus: got ifd=%b memd=%b ifr=%h memr=%h, expected all 0",
                     arbBus.if_done, arbBus.mem_done, arbBus.if_rdata, arbBus.mem_rdata);
        end
        rst = 1'b0;
    endtask

    task automatic test_if_read();
        access(1'b0, 1'b0, MemWord, 32'h0000_0100, '0, "if_read");
        checkData("if_read", 32'h93000013);
    endtask

    task automatic test_simultaneous();
        ExpItem      memE;
        ExpItem      ifE;
        bit          memSeen = 1'b0;
        bit          ifSeen = 1'b0;
        logic [16:0] idx;
        memE.data = {shadow[17'h203], shadow[17'h202], shadow[17'h201], shadow[17'h200]};
        memE.lat  = 6;
        ifE.data  = {shadow[17'h107], shadow[17'h106], shadow[17'h105], shadow[17'h104]};
        ifE.lat   = 13;
        memQ.push_back(memE);
        ifQ.push_back(ifE);
        arbBus.mem_req   = 1'b1;
        arbBus.mem_we    = 1'b0;
        arbBus.mem_width = MemWord;
        arbBus.mem_addr  = 32'h0000_0200;
        arbBus.if_req    = 1'b1;
        arbBus.if_addr   = 32'h0000_0104;
        for (int j = 1; j <= 30 && !ifSeen; j++) begin
            @(negedge clk);
            if (j >= 8 && j <= 11) begin
                idx = 17'h104 + 17'(j - 8);
                vectors++;
                if (ramA !== idx) begin
                    miscompares++;
                    $display("[TB] FAIL simul if addr cycle %0d: got %h, expected %h", j, ramA, idx);
                end
            end
            if (arbBus.mem_done === 1'b1) begin
                vectors++;
                if (memQ.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL simul mem done: got extra pulse at %0d, expected none", j);
                end else begin
                    memE = memQ.pop_front();
                    if (j != memE.lat || arbBus.mem_rdata !== memE.data || arbBus.if_done !== 1'b0) begin
                        miscompares++;
                        $display("[TB] FAIL simul mem done: got cycle=%0d data=%h ifd=%b, expected cycle=%0d data=%h ifd=0",
                                 j, arbBus.mem_rdata, arbBus.if_done, memE.lat, memE.data);
                    end
                end
                memSeen = 1'b1;
                arbBus.mem_req = 1'b0;
            end
            if (arbBus.if_done === 1'b1) begin
                vectors++;
                if (ifQ.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL simul if done: got extra pulse at %0d, expected none", j);
                end else begin
                    ifE = ifQ.pop_front();
                    if (j != ifE.lat || arbBus.if_rdata !== ifE.data) begin
                        miscompares++;
                        $display("[TB] FAIL simul if done: got cycle=%0d data=%h, expected cycle=%0d data=%h",
                                 j, arbBus.if_rdata, ifE.lat, ifE.data);
                    end
                end
                ifSeen = 1'b1;
                arbBus.if_req = 1'b0;
            end
        end
        if (!memSeen || !ifSeen) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL simul timeout: got memd=%b ifd=%b, expected both", memSeen, ifSeen);
            arbBus.mem_req = 1'b0;
            arbBus.if_req  = 1'b0;
            ifQ.delete();
            memQ.delete();
        end
        @(negedge clk);
    endtask

    task automatic test_byte_half();
        access(1'b1, 1'b1, MemByte, 32'h0000_0301, 32'h0000_00A5, "st_byte");
        access(1'b1, 1'b1, MemHalf, 32'h0000_0302, 32'h0000_BEEF, "st_half");
        access(1'b1, 1'b0, MemWord, 32'h0000_0300, '0, "ld_word");
        checkData("ld_word", 32'hBEEFA55C);
        access(1'b1, 1'b0, MemHalf, 32'h0000_0302, '0, "ld_half");
        checkData("ld_half", 32'h0000BEEF);
        access(1'b1, 1'b0, MemByte, 32'h0000_0301, '0, "ld_byte");
        checkData("ld_byte", 32'h000000A5);
        access(1'b1, 1'b0, 2'b11, 32'h0000_0300, '0, "ld_w11");
        checkData("ld_w11", 32'hBEEFA55C);
    endtask

    task automatic test_wrap();
        access(1'b1, 1'b0, MemWord, 32'h0001_FFFE, '0, "wrap");
        checkData("wrap", 32'h44332211);
        access(1'b1, 1'b0, MemByte, 32'hABC2_0010, '0, "high_addr");
        checkData("high_addr", 32'h000000EF);
    endtask

    task automatic test_reset_mid_store();
        arbBus.mem_req   = 1'b1;
        arbBus.mem_we    = 1'b1;
        arbBus.mem_width = MemWord;
        arbBus.mem_addr  = 32'h0000_0400;
        arbBus.mem_wdata = 32'h1122_3344;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        arbBus.mem_req = 1'b0;
        @(negedge clk);
        vectors++;
        if ({ramA, ramWr, ramDin} !== '0) begin
            miscompares++;
            $display("[TB] FAIL mid_rst ram: got a=%h wr=%b din=%h, expected all 0", ramA, ramWr, ramDin);
        end
        vectors++;
        if ({arbBus.if_done, arbBus.mem_done, arbBus.if_rdata, arbBus.mem_rdata} !== '0) begin
            miscompares++;
            $display("[TB] FAIL mid_rst bus: got ifd=%b memd=%b ifr=%h memr=%h, expected all 0",
                     arbBus.if_done, arbBus.mem_done, arbBus.if_rdata, arbBus.mem_rdata);
        end
        shadow[17'h400] = 8'h44;
        shadow[17'h401] = 8'h33;
        rst = 1'b0;
        access(1'b0, 1'b0, MemWord, 32'h0000_0400, '0, "if_after_rst");
        checkData("if_after_rst", 32'h00003344);
    endtask

    task automatic test_held_request();
        access(1'b1, 1'b1, MemWord, 32'h0000_0500, 32'hDEAD_BEEF, "held_st");
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            vectors++;
            if (ramWr !== 1'b0 || arbBus.mem_done !== 1'b0 || ramA !== 17'h00503) begin
                miscompares++;
                $display("[TB] FAIL held idle %0d: got wr=%b memd=%b a=%h, expected wr=0 memd=0 a=00503",
                         j, ramWr, arbBus.mem_done, ramA);
            end
        end
        access(1'b1, 1'b0, MemWord, 32'h0000_0500, '0, "held_ld");
        checkData("held_ld", 32'hDEADBEEF);
    endtask

    initial begin
        rst              = 1'b1;
        loadEn           = 1'b0;
        loadAddr         = '0;
        loadData         = '0;
        lastData         = '0;
        arbBus.if_req    = 1'b0;
        arbBus.if_addr   = '0;
        arbBus.mem_req   = 1'b0;
        arbBus.mem_we    = 1'b0;
        arbBus.mem_width = MemByte;
        arbBus.mem_addr  = '0;
        arbBus.mem_wdata = '0;
        test_reset();
        test_if_read();
        test_simultaneous();
        test_byte_half();
        test_wrap();
        test_reset_mid_store();
        test_held_request();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
